fnd_note_scan: RTL and testbench

Time-multiplexed 4-digit 7-segment controller for the piano note display. Captures each new key press (note plus flat flag) into a 4-deep history, newest first, and scans the history onto one shared active-high segment bus with one-hot digit enables. Sits between the key encoder/debouncer and the board FND pins. It replaces per-digit static decoders.

---
 rtl/fnd_note_scan.sv | 113 +++++++++++
 tb/tb_fnd_note_scan.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_note_scan.sv
// Four-digit multiplexed 7-segment driver for the piano note display.
// Keeps the last four key presses, newest on digit 0, and scans them out.
module fnd_note_scan #(
   parameter int SCAN_DIV     = 1000,
   parameter int IDLE_TIMEOUT = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] key,
   input  logic       flat,
   input  logic       clear,
   output logic [6:0] seg,
   output logic       seg_dp,
   output logic [3:0] dig_en,
   output logic       note_valid,
   output logic [2:0] hist_cnt
);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

   typedef struct packed {
      logic [2:0] code;
      logic       flat;
   } entry_t;

   entry_t [3:0]  hist;
   entry_t        new_e;
   entry_t        shown;
   logic [6:0]    key_q;
   logic [SW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic [1:0]    nidx;
   logic [IW-1:0] idle_cnt;
   logic          capture;

   function automatic logic [2:0] note_code(input logic [6:0] k);
      case (k)
         7'b1000000: note_code = 3'd1;
         7'b0100000: note_code = 3'd2;
         7'b0010000: note_code = 3'd3;
         7'b0001000: note_code = 3'd4;
         7'b0000100: note_code = 3'd5;
         7'b0000010: note_code = 3'd6;
         7'b0000001: note_code = 3'd7;
         default:    note_code = 3'd0;
      endcase
   endfunction

   function automatic logic [6:0] seg_of(input logic [2:0] code);
      case (code)
         3'd1:    seg_of = 7'b0111001;
         3'd2:    seg_of = 7'b0111111;
         3'd3:    seg_of = 7'b1111001;
         3'd4:    seg_of = 7'b1110001;
         3'd5:    seg_of = 7'b1111101;
         3'd6:    seg_of = 7'b1110111;
         3'd7:    seg_of = 7'b1111111;
         default: seg_of = 7'b1000000;
      endcase
   endfunction

   // Display uses the index after this edge so dig_en and seg always agree.
   always_comb begin
      capture = $onehot(key) && (key != key_q);
      new_e   = entry_t'({note_code(key), flat});
      nidx    = (scan_cnt == SCAN_LAST) ? idx + 2'd1 : idx;
      shown   = hist[nidx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist       <= '0;
         key_q      <= '0;
         scan_cnt   <= '0;
         idx        <= '0;
         idle_cnt   <= '0;
         seg        <= '0;
         seg_dp     <= 1'b0;
         dig_en     <= 4'b0001;
         note_valid <= 1'b0;
         hist_cnt   <= '0;
      end else begin
         key_q      <= key;
         note_valid <= 1'b0;
         scan_cnt   <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
         idx        <= nidx;
         seg        <= seg_of(shown.code);
         seg_dp     <= shown.flat;
         dig_en     <= 4'b0001 << nidx;

         if (clear) begin
            hist     <= '0;
            hist_cnt <= '0;
            idle_cnt <= '0;
         end else if (capture) begin
            hist       <= {hist[2:0], new_e};
            hist_cnt   <= (hist_cnt == 3'd4) ? 3'd4 : hist_cnt + 3'd1;
            idle_cnt   <= '0;
            note_valid <= 1'b1;
         end else if (hist_cnt != 3'd0) begin
            if (idle_cnt == IDLE_LAST) begin
               hist     <= '0;
               hist_cnt <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fnd_note_scan.sv
// Bench for fnd_note_scan: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized key traffic.
module tb_fnd_note_scan;
   localparam int SD = 4;
   localparam int IT = 20;
   localparam logic [6:0] DASH = 7'b1000000;
   localparam logic [6:0] K_C = 7'b1000000, K_D = 7'b0100000, K_E = 7'b0010000,
                          K_F = 7'b0001000, K_G = 7'b0000100, K_A = 7'b0000010,
                          K_B = 7'b0000001;

   logic       clk = 1'b0;
   logic       rst, flat, clear;
   logic [6:0] key;
   logic [6:0] seg;
   logic       seg_dp, note_valid;
   logic [3:0] dig_en;
   logic [2:0] hist_cnt;

   int tests = 0, fails = 0, nv_seen = 0;

   fnd_note_scan #(.SCAN_DIV(SD), .IDLE_TIMEOUT(IT)) dut (
      .clk(clk), .rst(rst), .key(key), .flat(flat), .clear(clear),
      .seg(seg), .seg_dp(seg_dp), .dig_en(dig_en),
      .note_valid(note_valid), .hist_cnt(hist_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference model: history as a newest-first queue of code*2+flat.
   logic [6:0] seg_tab [8] = '{7'b1000000, 7'b0111001, 7'b0111111, 7'b1111001,
                               7'b1110001, 7'b1111101, 7'b1110111, 7'b1111111};
   int         mq[$];
   logic [6:0] m_kprev;
   int         m_t, m_idle, m_idx, m_pos;
   logic [6:0] e_seg;
   logic       e_dp, e_nv, m_cap;
   logic [3:0] e_dig;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete(); m_kprev = '0; m_t = 0; m_idle = 0;
         e_seg = '0; e_dp = 1'b0; e_dig = 4'b0001; e_nv = 1'b0;
      end else begin
         m_t++;
         m_idx = (m_t / SD) % 4;
         if (m_idx < mq.size()) begin
            e_seg = seg_tab[mq[m_idx] / 2];
            e_dp  = (mq[m_idx] % 2) == 1;
         end else begin
            e_seg = DASH; e_dp = 1'b0;
         end
         e_dig = 4'(1 << m_idx);
         m_cap = ($countones(key) == 1) && (key != m_kprev);
         m_kprev = key;
         e_nv = 1'b0;
         if (clear) begin
            mq.delete(); m_idle = 0;
         end else if (m_cap) begin
            m_pos = 0;
            for (int b = 0; b < 7; b++) if (key[b]) m_pos = b;
            mq.push_front((7 - m_pos) * 2 + (flat ? 1 : 0));
            if (mq.size() > 4) void'(mq.pop_back());
            m_idle = 0; e_nv = 1'b1;
         end else if (mq.size() > 0) begin
            m_idle++;
            if (m_idle == IT) begin mq.delete(); m_idle = 0; end
         end
      end
      #1;
      chk("seg", 32'(seg), 32'(e_seg));
      chk("seg_dp", 32'(seg_dp), 32'(e_dp));
      chk("dig_en", 32'(dig_en), 32'(e_dig));
      chk("note_valid", 32'(note_valid), 32'(e_nv));
      chk("hist_cnt", 32'(hist_cnt), 32'(mq.size()));
      if (note_valid === 1'b1) nv_seen++;
   end

   // Watch one full frame; each enabled digit must show its literal pattern.
   task automatic check_frame(input string nm, input logic [3:0][6:0] s, input logic [3:0] d);
      for (int c = 0; c < 4 * SD; c++) begin
         step(1);
         for (int i = 0; i < 4; i++)
            if (dig_en === 4'(1 << i)) begin
               chk({nm, "_seg"}, 32'(seg), 32'(s[i]));
               chk({nm, "_dp"}, 32'(seg_dp), 32'(d[i]));
            end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   int base, k;
   int r;

   initial begin
      rst = 1'b1; key = '0; flat = 1'b0; clear = 1'b0;
      step(1);
      chk("rst_seg", 32'(seg), 32'd0);
      chk("rst_dig", 32'(dig_en), 32'b0001);
      chk("rst_cnt", 32'(hist_cnt), 32'd0);
      step(2);
      rst = 1'b0;
      step(1);
      chk("rel_seg", 32'(seg), 32'(DASH));
      chk("rel_dig", 32'(dig_en), 32'b0001);
      step(2);
      chk("rel_dig_t3", 32'(dig_en), 32'b0001);
      step(1);
      chk("rel_dig_t4", 32'(dig_en), 32'b0010);
      check_frame("dash", {DASH, DASH, DASH, DASH}, 4'b0000);

      // capture order
      base = nv_seen;
      key = K_C; step(2); key = '0; step(2);
      key = K_E; flat = 1'b1; step(2); key = '0; flat = 1'b0; step(2);
      chk("order_pulses", 32'(nv_seen - base), 32'd2);
      chk("order_cnt", 32'(hist_cnt), 32'd2);
      check_frame("order", {DASH, DASH, 7'b0111001, 7'b1111001}, 4'b0001);

      // hold and change, then multi-hot
      base = nv_seen;
      key = K_G; step(50); key = K_A; step(3);
      chk("hold_pulses", 32'(nv_seen - base), 32'd2);
      base = nv_seen;
      key = 7'b0000110; step(3); key = '0; step(2);
      chk("multihot_pulses", 32'(nv_seen - base), 32'd0);

      // overflow
      clear = 1'b1; step(1); clear = 1'b0;
      key = K_C; step(1); key = K_D; step(1); key = K_E; step(1);
      key = K_F; step(1); key = K_G; step(1); key = '0; step(1);
      chk("ovf_cnt", 32'(hist_cnt), 32'd4);
      check_frame("ovf", {7'b0111111, 7'b1111001, 7'b1110001, 7'b1111101}, 4'b0000);

      // idle timeout from a single capture
      clear = 1'b1; step(1); clear = 1'b0;
      key = K_A; step(1);
      chk("idle_cap_nv", 32'(note_valid), 32'd1);
      key = '0; k = 0;
      while (hist_cnt !== 3'd0 && k < 2 * IT) begin step(1); k++; end
      chk("idle_cycles", 32'(k), 32'(IT));

      // capture on the timeout edge wins and restarts the timer
      key = K_C; step(1); key = '0; step(IT - 1);
      key = K_D; step(1); key = '0;
      chk("to_cap_cnt", 32'(hist_cnt), 32'd2);
      chk("to_cap_nv", 32'(note_valid), 32'd1);
      step(IT - 1);
      chk("to_restart_hold", 32'(hist_cnt), 32'd2);
      step(1);
      chk("to_restart_clr", 32'(hist_cnt), 32'd0);

      // clear against capture
      key = K_C; step(1); key = '0; step(1);
      base = nv_seen;
      key = K_B; clear = 1'b1; step(1); key = '0; clear = 1'b0;
      chk("clr_cnt", 32'(hist_cnt), 32'd0);
      step(1);
      chk("clr_pulses", 32'(nv_seen - base), 32'd0);
      check_frame("clr", {DASH, DASH, DASH, DASH}, 4'b0000);

      // reset mid-frame
      key = K_F; step(1); key = '0; step(6);
      rst = 1'b1; step(1);
      chk("mrst_dig", 32'(dig_en), 32'b0001);
      chk("mrst_seg", 32'(seg), 32'd0);
      chk("mrst_cnt", 32'(hist_cnt), 32'd0);
      rst = 1'b0; step(3);
      chk("mrst_scan_t3", 32'(dig_en), 32'b0001);
      step(1);
      chk("mrst_scan_t4", 32'(dig_en), 32'b0010);

      // randomized traffic, checked by the model every cycle
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 30)      key = '0;
         else if (r < 70) key = 7'(1 << $urandom_range(0, 6));
         else if (r < 80) key = key;
         else if (r < 97) key = 7'($urandom_range(0, 127));
         else             key = '0;
         flat  = 1'($urandom_range(0, 1));
         clear = ($urandom_range(0, 59) == 0);
         rst   = ($urandom_range(0, 699) == 0);
         if (r >= 97) begin
            clear = 1'b0; rst = 1'b0; step(IT + 5);
         end else begin
            step(1);
         end
      end
      rst = 1'b0; clear = 1'b0; key = '0;
      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
